ascii_arbiter: RTL

//  Shares the single-character ASCII write interface of the character display among several

---
 rtl/ascii_arb_pkg.sv | 11 +
 rtl/ascii_arbiter_if.sv | 24 ++
 rtl/ascii_arb_rr_pick.sv | 31 +++
 rtl/ascii_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ascii_arb_pkg.sv
// Shared types and constants for the ASCII display arbiter.
package ascii_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } arb_state_e;

  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

endpackage

// File: rtl/ascii_arbiter_if.sv
// Requester bus plus the display-side character strobe of the ASCII arbiter.
interface ascii_arbiter_if #(
  parameter int p_num_reqs = 4
);
  localparam int IDX_W = $clog2(p_num_reqs);

  logic [8*p_num_reqs-1:0] req_ascii;
  logic [p_num_reqs-1:0]   req_val;
  logic [p_num_reqs-1:0]   req_rdy;
  logic [7:0]              ascii;
  logic                    ascii_val;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;

  modport master (
    output req_ascii, req_val,
    input  req_rdy, ascii, ascii_val, grant_id, busy
  );

  modport slave (
    input  req_ascii, req_val,
    output req_rdy, ascii, ascii_val, grant_id, busy
  );
endinterface

// File: rtl/ascii_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last', wrapping.
module ascii_arb_rr_pick #(
  parameter int p_num_reqs = 4,
  localparam int IDX_W = $clog2(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] eligible,
  input  logic [IDX_W-1:0]      last,
  output logic [p_num_reqs-1:0] grant,
  output logic [IDX_W-1:0]      idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= p_num_reqs; k++) begin
      pos = IDX_W'((int'(last) + k) % p_num_reqs);
      if (!found && eligible[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/ascii_arbiter.sv
// Round-robin arbiter feeding single characters to the display with a forced idle gap.
// Optional line lock (whole line per requester) is enabled by defining ASCII_ARB_LINE_LOCK_EN.
module ascii_arbiter
  import ascii_arb_pkg::*;
#(
  parameter int p_num_reqs     = 4,
  parameter int p_gap_cycles   = 2,
  parameter int p_lock_timeout = 64
) (
  input logic             clk,
  input logic             rst,
  ascii_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(p_num_reqs);
  localparam int CNT_W = (p_gap_cycles > 1) ? $clog2(p_gap_cycles) : 1;

  if (p_num_reqs < 2 || p_gap_cycles < 0 || p_lock_timeout < 1) begin : g_param_check
    $error("ascii_arbiter: illegal parameter value");
  end

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [7:0]             ascii_q, ascii_d;
  logic                   ascii_val_q, ascii_val_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;

  logic [p_num_reqs-1:0]  eligible;
  logic [p_num_reqs-1:0]  grant;
  logic [p_num_reqs-1:0]  rdy;
  logic [IDX_W-1:0]       pick_idx;
  logic [7:0]             pick_ascii;
  logic                   xfer;

  ascii_arb_rr_pick #(.p_num_reqs(p_num_reqs)) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .grant    (grant),
    .idx      (pick_idx)
  );

  // Handshake only in IDLE; held off while reset is asserted.
  assign rdy         = (state_q == IDLE && !rst) ? grant : '0;
  assign xfer        = |rdy;
  assign bus.req_rdy = rdy;

  always_comb begin
    pick_ascii = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (pick_idx == IDX_W'(i)) pick_ascii = bus.req_ascii[8*i +: 8];
    end
  end

`ifdef ASCII_ARB_LINE_LOCK_EN
  localparam int TO_W = $clog2(p_lock_timeout + 1);

  logic             lock_q;
  logic [IDX_W-1:0] lock_id_q;
  logic [TO_W-1:0]  idle_cnt_q;

  assign eligible = lock_q ? (bus.req_val & (p_num_reqs'(1) << lock_id_q)) : bus.req_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      idle_cnt_q <= '0;
    end else if (xfer) begin
      idle_cnt_q <= '0;
      if (pick_ascii != ASCII_NEWLINE) begin
        lock_q    <= 1'b1;
        lock_id_q <= pick_idx;
      end else begin
        // While locked only lock_id can transfer, so a newline here always ends its own line.
        lock_q <= 1'b0;
      end
    end else if (lock_q && !bus.req_val[lock_id_q]) begin
      if (idle_cnt_q == TO_W'(p_lock_timeout - 1)) begin
        lock_q     <= 1'b0;
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_q <= '0;
    end
  end
`else
  assign eligible = bus.req_val;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    ascii_d     = ascii_q;
    ascii_val_d = 1'b0;
    grant_id_d  = grant_id_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          ascii_d     = pick_ascii;
          ascii_val_d = 1'b1;
          grant_id_d  = pick_idx;
          last_d      = pick_idx;
          if (p_gap_cycles > 0) begin
            state_d = GAP;
            cnt_d   = CNT_W'(p_gap_cycles - 1);
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IDX_W'(p_num_reqs - 1);
      ascii_q     <= '0;
      ascii_val_q <= 1'b0;
      grant_id_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ascii_q     <= ascii_d;
      ascii_val_q <= ascii_val_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign bus.ascii     = ascii_q;
  assign bus.ascii_val = ascii_val_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q == GAP) || ascii_val_q;

endmodule
